// File: rtl/mul_seq_r4_if.sv
// Operand/product handshake bundle for mul_seq_r4: valid/ready in, valid/ready out.
interface mul_seq_r4_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/mul_seq_r4.sv
// Sequential unsigned WIDTH x WIDTH multiplier, one radix-4 digit of b per cycle,
// each digit multiplied against a by a row of exact 2x2 cells.
module mul_seq_r4 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
    input logic         clk,
    input logic         rst_n,
    mul_seq_r4_if.slave bus
);
    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("mul_seq_r4: WIDTH must be even and >= 2");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int               DIGITS = WIDTH / 2;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(DIGITS - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] product;
    logic               out_valid;
    logic               busy;

    logic [1:0]         d;
    logic [WIDTH+1:0]   pp;
    logic [2*WIDTH-1:0] acc_next;

    function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
        logic p00;
        logic p11;
        p00 = x[0] & y[0];
        p11 = x[1] & y[1];
        return {p11 & p00, p11 & ~p00, (x[1] & y[0]) ^ (x[0] & y[1]), p00};
    endfunction

    always_comb begin
        d  = 2'(b_reg >> {cnt, 1'b0});
        pp = '0;
        for (int i = 0; i < DIGITS; i++) begin
            pp = pp + ((WIDTH+2)'(mul2(a_reg[2*i +: 2], d)) << (2*i));
        end
        acc_next = acc + ((2*WIDTH)'(pp) << {cnt, 1'b0});
    end

    // DONE forwards out_ready so a new operand can be taken on the output handshake edge.
    assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
    assign bus.out_valid = out_valid;
    assign bus.product   = product;
    assign bus.busy      = busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.a;
                        b_reg <= bus.b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    if (cnt == LAST) begin
                        product   <= acc_next;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        if (bus.in_valid) begin
                            a_reg <= bus.a;
                            b_reg <= bus.b;
                            acc   <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq_r4.sv
// Directed and streaming checks of mul_seq_r4 at WIDTH = 2, 8 and 16.
module tb_mul_seq_r4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mul_seq_r4_if #(.WIDTH(2))  i2  ();
    mul_seq_r4_if #(.WIDTH(8))  i8  ();
    mul_seq_r4_if #(.WIDTH(16)) i16 ();

    mul_seq_r4 #(.WIDTH(2))  u2  (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
    mul_seq_r4 #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
    mul_seq_r4 #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave));

    task automatic test_reset();
        i2.in_valid = 0;  i2.a = 0;  i2.b = 0;  i2.out_ready = 0;
        i8.in_valid = 0;  i8.a = 0;  i8.b = 0;  i8.out_ready = 0;
        i16.in_valid = 0; i16.a = 0; i16.b = 0; i16.out_ready = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        tests++;
        if ({i8.in_ready, i8.out_valid, i8.busy} !== 3'b100) begin
            fails++; $display("FAIL reset_flags8 got %b want 100", {i8.in_ready, i8.out_valid, i8.busy});
        end
        tests++;
        if (i8.product !== 16'h0) begin
            fails++; $display("FAIL reset_product8 got %h want 0", i8.product);
        end
        tests++;
        if ({i2.in_ready, i2.out_valid, i16.in_ready, i16.out_valid} !== 4'b1010) begin
            fails++; $display("FAIL reset_flags2_16 got %b want 1010",
                              {i2.in_ready, i2.out_valid, i16.in_ready, i16.out_valid});
        end
    endtask

    task automatic test_width2();
        i2.a = 2'd3; i2.b = 2'd3; i2.in_valid = 1; i2.out_ready = 1;
        @(posedge clk); #1;
        i2.in_valid = 0;
        tests++;
        if ({i2.busy, i2.in_ready, i2.out_valid} !== 3'b100) begin
            fails++; $display("FAIL w2_busy got %b want 100", {i2.busy, i2.in_ready, i2.out_valid});
        end
        @(posedge clk); #1;
        tests++;
        if (i2.out_valid !== 1'b1 || i2.product !== 4'd9) begin
            fails++; $display("FAIL w2_product got v=%b p=%0d want v=1 p=9", i2.out_valid, i2.product);
        end
        @(posedge clk); #1;
        tests++;
        if (i2.out_valid !== 1'b0 || i2.in_ready !== 1'b1) begin
            fails++; $display("FAIL w2_return_idle got v=%b r=%b want v=0 r=1", i2.out_valid, i2.in_ready);
        end
    endtask

    // One full WIDTH=8 operation from IDLE; operands are scrambled after accept.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] exp, input string nm);
        int n;
        i8.a = ta; i8.b = tb; i8.in_valid = 1; i8.out_ready = 1;
        @(posedge clk); #1;
        i8.in_valid = 0; i8.a = ~ta; i8.b = ~tb;
        tests++;
        if (i8.busy !== 1'b1) begin
            fails++; $display("FAIL %s_accept busy=%b want 1", nm, i8.busy);
        end
        n = 0;
        while (i8.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (n !== 4) begin
            fails++; $display("FAIL %s_latency got %0d want 4", nm, n);
        end
        tests++;
        if (i8.product !== exp) begin
            fails++; $display("FAIL %s_product got %h want %h", nm, i8.product, exp);
        end
        @(posedge clk); #1;
        tests++;
        if (i8.out_valid !== 1'b0 || i8.in_ready !== 1'b1) begin
            fails++; $display("FAIL %s_handshake v=%b r=%b want v=0 r=1", nm, i8.out_valid, i8.in_ready);
        end
    endtask

    task automatic test_width8();
        op8(8'd255, 8'd255, 16'hFE01, "max");
        op8(8'hA5,  8'h3C,  16'h26AC, "a5x3c");
        op8(8'd0,   8'd200, 16'h0000, "zero_a");
        op8(8'd1,   8'd0,   16'h0000, "zero_b");
    endtask

    task automatic test_backpressure();
        int n;
        i8.a = 8'h12; i8.b = 8'h34; i8.in_valid = 1; i8.out_ready = 0;
        @(posedge clk); #1;
        i8.in_valid = 0;
        n = 0;
        while (i8.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (n !== 4 || i8.product !== 16'd936) begin
            fails++; $display("FAIL bp_first got lat=%0d p=%0d want lat=4 p=936", n, i8.product);
        end
        i8.a = 8'd2; i8.b = 8'd7; i8.in_valid = 1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (i8.out_valid !== 1'b1 || i8.product !== 16'd936 || i8.in_ready !== 1'b0 || i8.busy !== 1'b0)
                n++;
        end
        tests++;
        if (n !== 0) begin
            fails++; $display("FAIL bp_hold got %0d unstable cycles want 0", n);
        end
        i8.out_ready = 1;
        #1;
        tests++;
        if (i8.in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_ready_pass got %b want 1", i8.in_ready);
        end
        @(posedge clk); #1;
        i8.in_valid = 0;
        tests++;
        if (i8.out_valid !== 1'b0 || i8.busy !== 1'b1) begin
            fails++; $display("FAIL bp_same_edge got v=%b busy=%b want v=0 busy=1", i8.out_valid, i8.busy);
        end
        n = 0;
        while (i8.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (n !== 4 || i8.product !== 16'd14) begin
            fails++; $display("FAIL bp_second got lat=%0d p=%0d want lat=4 p=14", n, i8.product);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n;
        i8.a = 8'd200; i8.b = 8'd100; i8.in_valid = 1; i8.out_ready = 1;
        @(posedge clk); #1;
        i8.in_valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (i8.out_valid !== 1'b0) n++;
            @(posedge clk); #1;
        end
        tests++;
        if (n !== 0) begin
            fails++; $display("FAIL rstmid_no_valid got %0d valid cycles want 0", n);
        end
        tests++;
        if (i8.in_ready !== 1'b1 || i8.product !== 16'h0) begin
            fails++; $display("FAIL rstmid_state got r=%b p=%h want r=1 p=0", i8.in_ready, i8.product);
        end
        op8(8'd12, 8'd11, 16'd132, "after_rst");
    endtask

    // Random valid/ready gaps; inputs change at negedge, handshakes resolved just after.
    task automatic test_stream(input int w, input int count);
        logic [31:0] q[$];
        logic [31:0] pa, pb, exp, got;
        logic        pend, fi, fo;
        int          sent, recv, cyc, drops;
        pend = 0; sent = 0; recv = 0; cyc = 0; drops = 0; pa = 0; pb = 0;
        while (recv < count && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (!pend && sent < count && $urandom_range(3) != 0) begin
                pa = (w == 8) ? $urandom_range(255) : $urandom_range(65535);
                pb = (w == 8) ? $urandom_range(255) : $urandom_range(65535);
                pend = 1;
            end
            if (w == 8) begin
                i8.in_valid = pend; i8.a = pend ? pa[7:0] : 8'($urandom);
                i8.b = pend ? pb[7:0] : 8'($urandom); i8.out_ready = ($urandom_range(2) != 0);
            end else begin
                i16.in_valid = pend; i16.a = pend ? pa[15:0] : 16'($urandom);
                i16.b = pend ? pb[15:0] : 16'($urandom); i16.out_ready = ($urandom_range(2) != 0);
            end
            #1;
            fi  = (w == 8) ? (i8.in_valid & i8.in_ready)   : (i16.in_valid & i16.in_ready);
            fo  = (w == 8) ? (i8.out_valid & i8.out_ready) : (i16.out_valid & i16.out_ready);
            got = (w == 8) ? 32'(i8.product) : i16.product;
            if (fo) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL stream%0d_extra got %h want no result", w, got);
                end else begin
                    exp = q.pop_front();
                    recv++;
                    if (got !== exp) begin
                        fails++; $display("FAIL stream%0d_product #%0d got %h want %h", w, recv, got, exp);
                    end
                end
            end
            if (fi) begin
                q.push_back(pa * pb);
                pend = 0;
                sent++;
            end
        end
        i8.in_valid = 0; i16.in_valid = 0;
        if (recv < count) drops = count - recv;
        tests++;
        if (drops != 0) begin
            fails++; $display("FAIL stream%0d_count got %0d results want %0d", w, recv, count);
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_width2();
        test_width8();
        test_backpressure();
        test_reset_mid();
        test_stream(8, 500);
        test_stream(16, 500);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
